// File: rtl/nn_accel_pkg.sv
// rtl/nn_accel_pkg.sv - shared types and constants for the bias/ReLU accelerator
package nn_accel_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_IN     = 3'd1,
      WAIT_IN   = 3'd2,
      RD_BIAS   = 3'd3,
      WAIT_BIAS = 3'd4,
      WR_OUT    = 3'd5
   } state_e;

   localparam logic [3:0] REG_START     = 4'd0;
   localparam logic [3:0] REG_IN_ADDR   = 4'd2;
   localparam logic [3:0] REG_BIAS_ADDR = 4'd3;
   localparam logic [3:0] REG_OUT_ADDR  = 4'd4;
   localparam logic [3:0] REG_LEN       = 4'd5;
   localparam logic [3:0] REG_CTRL      = 4'd6;

   localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] Q_MIN = 32'h8000_0000;

   // Byte address of word element idx in a vector starting at base.
   function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + {idx[29:0], 2'b00};
   endfunction

endpackage

// File: rtl/bias_relu_if.sv
// rtl/bias_relu_if.sv - CPU register port and memory master port bundles
interface bias_relu_csr_if;
   logic        slave_waitrequest;
   logic [3:0]  slave_address;
   logic        slave_read;
   logic [31:0] slave_readdata;
   logic        slave_write;
   logic [31:0] slave_writedata;

   modport slave (
      output slave_waitrequest, slave_readdata,
      input  slave_address, slave_read, slave_write, slave_writedata
   );
   modport master (
      input  slave_waitrequest, slave_readdata,
      output slave_address, slave_read, slave_write, slave_writedata
   );
endinterface

interface bias_relu_mem_if;
   logic        master_waitrequest;
   logic [31:0] master_address;
   logic        master_read;
   logic [31:0] master_readdata;
   logic        master_readdatavalid;
   logic        master_write;
   logic [31:0] master_writedata;

   modport master (
      input  master_waitrequest, master_readdata, master_readdatavalid,
      output master_address, master_read, master_write, master_writedata
   );
   modport slave (
      output master_waitrequest, master_readdata, master_readdatavalid,
      input  master_address, master_read, master_write, master_writedata
   );
endinterface

// File: rtl/sat_add_relu.sv
// rtl/sat_add_relu.sv - Q16.16 saturating add with optional ReLU clamp
module sat_add_relu
   import nn_accel_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        relu_en,
   output logic [31:0] y
);

   logic [32:0] sum;
   logic [31:0] sat;

   always_comb begin
      sum = {a[31], a} + {b[31], b};
      // Top two sum bits disagree only when the 32-bit result overflowed.
      case (sum[32:31])
         2'b01:   sat = Q_MAX;
         2'b10:   sat = Q_MIN;
         default: sat = sum[31:0];
      endcase
      y = (relu_en && sat[31]) ? 32'h0000_0000 : sat;
   end

endmodule

// File: rtl/bias_relu.sv
// rtl/bias_relu.sv - streams in[i]+bias[i] through saturation/ReLU into out[i]
module bias_relu
   import nn_accel_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   bias_relu_csr_if.slave         csr,
   bias_relu_mem_if.master        mem
);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] in_addr_q, in_addr_d;
   logic [31:0] bias_addr_q, bias_addr_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic [31:0] len_q, len_d;
   logic        relu_q, relu_d;
   logic [31:0] in_val_q, in_val_d;
   logic [31:0] bias_val_q, bias_val_d;
   logic [31:0] result;

   sat_add_relu u_sat (
      .a       (in_val_q),
      .b       (bias_val_q),
      .relu_en (relu_q),
      .y       (result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_addr_q   <= '0;
         bias_addr_q <= '0;
         out_addr_q  <= '0;
         len_q       <= '0;
         relu_q      <= 1'b0;
         in_val_q    <= '0;
         bias_val_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_addr_q   <= in_addr_d;
         bias_addr_q <= bias_addr_d;
         out_addr_q  <= out_addr_d;
         len_q       <= len_d;
         relu_q      <= relu_d;
         in_val_q    <= in_val_d;
         bias_val_q  <= bias_val_d;
      end
   end

   always_comb begin
      state_d               = state_q;
      cnt_d                 = cnt_q;
      in_addr_d             = in_addr_q;
      bias_addr_d           = bias_addr_q;
      out_addr_d            = out_addr_q;
      len_d                 = len_q;
      relu_d                = relu_q;
      in_val_d              = in_val_q;
      bias_val_d            = bias_val_q;
      csr.slave_waitrequest = 1'b1;
      csr.slave_readdata    = '0;
      mem.master_read       = 1'b0;
      mem.master_write      = 1'b0;
      mem.master_address    = '0;
      mem.master_writedata  = '0;

      case (state_q)
         IDLE: begin
            csr.slave_waitrequest = 1'b0;
            if (csr.slave_read) begin
               case (csr.slave_address)
                  REG_START:     csr.slave_readdata = cnt_q;
                  REG_IN_ADDR:   csr.slave_readdata = in_addr_q;
                  REG_BIAS_ADDR: csr.slave_readdata = bias_addr_q;
                  REG_OUT_ADDR:  csr.slave_readdata = out_addr_q;
                  REG_LEN:       csr.slave_readdata = len_q;
                  REG_CTRL:      csr.slave_readdata = {31'd0, relu_q};
                  default:       csr.slave_readdata = '0;
               endcase
            end
            if (csr.slave_write) begin
               case (csr.slave_address)
                  REG_START: begin
                     cnt_d = '0;
                     if (len_q != 32'd0) state_d = RD_IN;
                  end
                  REG_IN_ADDR:   in_addr_d   = csr.slave_writedata;
                  REG_BIAS_ADDR: bias_addr_d = csr.slave_writedata;
                  REG_OUT_ADDR:  out_addr_d  = csr.slave_writedata;
                  REG_LEN:       len_d       = csr.slave_writedata;
                  REG_CTRL:      relu_d      = csr.slave_writedata[0];
                  default: ;
               endcase
            end
         end
         RD_IN: begin
            mem.master_read    = 1'b1;
            mem.master_address = elem_addr(in_addr_q, cnt_q);
            if (!mem.master_waitrequest) state_d = WAIT_IN;
         end
         WAIT_IN: begin
            if (mem.master_readdatavalid) begin
               in_val_d = mem.master_readdata;
               state_d  = RD_BIAS;
            end
         end
         RD_BIAS: begin
            mem.master_read    = 1'b1;
            mem.master_address = elem_addr(bias_addr_q, cnt_q);
            if (!mem.master_waitrequest) state_d = WAIT_BIAS;
         end
         WAIT_BIAS: begin
            if (mem.master_readdatavalid) begin
               bias_val_d = mem.master_readdata;
               state_d    = WR_OUT;
            end
         end
         WR_OUT: begin
            mem.master_write     = 1'b1;
            mem.master_address   = elem_addr(out_addr_q, cnt_q);
            mem.master_writedata = result;
            if (!mem.master_waitrequest) begin
               cnt_d   = cnt_q + 32'd1;
               state_d = (cnt_q + 32'd1 < len_q) ? RD_IN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bias_relu.sv
// tb/tb_bias_relu.sv - scoreboard bench with memory model for bias_relu
module tb_bias_relu;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bias_relu_csr_if csr();
   bias_relu_mem_if mem();

   bias_relu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .csr   (csr),
      .mem   (mem)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } op_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   localparam int LIMIT = 5000;

   int checks = 0;
   int errors = 0;
   int wlat = 0;
   int rlat = 0;
   int cyc = 0;
   int wait_cnt = 0;
   bit violation = 0;
   logic [31:0] mem_arr [bit [31:0]];
   op_t  exp_q[$];
   rsp_t rsp_q[$];
   logic [31:0] in_v[$];
   logic [31:0] bias_v[$];

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return 32'h0;
   endfunction

   // Reference: exact integer sum clamped to the signed 32-bit range, then ReLU.
   function automatic logic [31:0] ref_f(input logic [31:0] a, input logic [31:0] b, input bit relu);
      longint s;
      longint mx;
      longint mn;
      mx = 64'sd2147483647;
      mn = -64'sd2147483648;
      s = longint'($signed(a)) + longint'($signed(b));
      if (s > mx) s = mx;
      if (s < mn) s = mn;
      if (relu && s < 0) s = 0;
      return s[31:0];
   endfunction

   task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", name, got, exp);
      end
   endtask

   // Memory model: fixed waitrequest count per access, read data rlat cycles after acceptance.
   initial begin
      rsp_t r;
      mem.master_waitrequest   = 1'b0;
      mem.master_readdatavalid = 1'b0;
      mem.master_readdata      = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            rsp_q.delete();
            wait_cnt = 0;
            mem.master_waitrequest   = 1'b0;
            mem.master_readdatavalid = 1'b0;
            mem.master_readdata      = 32'h0;
         end else begin
            mem.master_readdatavalid = 1'b0;
            mem.master_readdata      = $urandom;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
               mem.master_readdatavalid = 1'b1;
               mem.master_readdata      = rsp_q[0].data;
               void'(rsp_q.pop_front());
            end
            if (mem.master_read || mem.master_write) begin
               if (wait_cnt < wlat) begin
                  mem.master_waitrequest = 1'b1;
                  wait_cnt++;
               end else begin
                  mem.master_waitrequest = 1'b0;
                  wait_cnt = 0;
                  if (mem.master_read) begin
                     r.due  = cyc + 1 + rlat;
                     r.data = rd_word(mem.master_address);
                     rsp_q.push_back(r);
                  end else begin
                     mem_arr[mem.master_address] = mem.master_writedata;
                  end
               end
            end else begin
               mem.master_waitrequest = 1'b0;
               wait_cnt = 0;
            end
         end
      end
   end

   // Monitor: every accepted master access is popped from the scoreboard and compared.
   initial begin
      op_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (!mem.master_read && !mem.master_write &&
                (mem.master_address != 0 || mem.master_writedata != 0)) violation = 1;
            if (mem.master_read && mem.master_writedata != 0) violation = 1;
            if (!csr.slave_waitrequest && (mem.master_read || mem.master_write)) violation = 1;
            if ((mem.master_read || mem.master_write) && !mem.master_waitrequest) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_op wr=%0d addr=%08h data=%08h exp=none",
                           mem.master_write, mem.master_address, mem.master_writedata);
               end else begin
                  e = exp_q.pop_front();
                  if (e.wr != mem.master_write || e.addr !== mem.master_address ||
                      (e.wr && e.data !== mem.master_writedata)) begin
                     errors++;
                     $display("FAIL master_op got wr=%0d addr=%08h data=%08h exp wr=%0d addr=%08h data=%08h",
                              mem.master_write, mem.master_address, mem.master_writedata,
                              e.wr, e.addr, e.data);
                  end
               end
            end
         end
      end
   end

   task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      csr.slave_address   = a;
      csr.slave_writedata = d;
      csr.slave_write     = 1'b1;
      #1;
      n = 0;
      while (csr.slave_waitrequest && n < LIMIT) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= LIMIT) begin
         checks++;
         errors++;
         $display("FAIL cpu_write_timeout got=stalled exp=accepted");
      end
      @(posedge clk);
      #1;
      csr.slave_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int stall);
      @(negedge clk);
      csr.slave_address = a;
      csr.slave_read    = 1'b1;
      #1;
      stall = 0;
      while (csr.slave_waitrequest && stall < LIMIT) begin
         @(negedge clk);
         #1;
         stall++;
      end
      if (stall >= LIMIT) begin
         checks++;
         errors++;
         $display("FAIL cpu_read_timeout got=stalled exp=accepted");
      end
      d = csr.slave_readdata;
      @(posedge clk);
      #1;
      csr.slave_read = 1'b0;
   endtask

   task automatic push_expected(input int n, input logic [31:0] ib, input logic [31:0] bb,
                                input logic [31:0] ob, input bit relu);
      op_t o;
      for (int i = 0; i < n; i++) begin
         mem_arr[ib + 4*i] = in_v[i];
         mem_arr[bb + 4*i] = bias_v[i];
         o.wr = 0; o.addr = ib + 4*i; o.data = 0; exp_q.push_back(o);
         o.wr = 0; o.addr = bb + 4*i; o.data = 0; exp_q.push_back(o);
         o.wr = 1; o.addr = ob + 4*i; o.data = ref_f(in_v[i], bias_v[i], relu); exp_q.push_back(o);
      end
   endtask

   task automatic configure(input int n, input logic [31:0] ib, input logic [31:0] bb,
                            input logic [31:0] ob, input bit relu);
      cpu_write(4'd2, ib);
      cpu_write(4'd3, bb);
      cpu_write(4'd4, ob);
      cpu_write(4'd5, n);
      cpu_write(4'd6, {31'd0, relu});
   endtask

   task automatic run(input string name, input int n, input logic [31:0] ib, input logic [31:0] bb,
                      input logic [31:0] ob, input bit relu, input bit wr_cfg,
                      input int wl, input int rl, output int stall);
      logic [31:0] d;
      wlat = wl;
      rlat = rl;
      violation = 0;
      push_expected(n, ib, bb, ob, relu);
      if (wr_cfg) configure(n, ib, bb, ob, relu);
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, stall);
      check_word({name, "_count"}, d, n);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (violation) begin
         errors++;
         $display("FAIL %s_strobe_rules got=violation exp=clean", name);
      end
   endtask

   task automatic set_vec(input logic [31:0] a, input logic [31:0] b);
      in_v.delete();
      bias_v.delete();
      in_v.push_back(a);
      bias_v.push_back(b);
   endtask

   initial begin
      logic [31:0] d;
      int st;
      int n;
      bit relu;
      csr.slave_address   = 4'd0;
      csr.slave_read      = 1'b0;
      csr.slave_write     = 1'b0;
      csr.slave_writedata = 32'd0;

      #2;
      check_word("reset_waitreq", {31'd0, csr.slave_waitrequest}, 32'd0);
      check_word("reset_strobes", {30'd0, mem.master_read, mem.master_write}, 32'd0);
      check_word("reset_addr", mem.master_address, 32'd0);
      csr.slave_read = 1'b1;
      csr.slave_address = 4'd2;
      #1;
      check_word("reset_readdata", csr.slave_readdata, 32'd0);
      csr.slave_read = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      set_vec(32'h0001_0000, 32'h0000_8000);
      run("basic", 1, 32'h1000, 32'h2000, 32'h3000, 0, 1, 0, 0, st);
      check_word("basic_value", rd_word(32'h3000), 32'h0001_8000);
      configure(1, 32'h1000, 32'h2000, 32'h3000, 0);
      cpu_read(4'd5, d, st);
      check_word("reg5_readback", d, 32'd1);
      cpu_read(4'd3, d, st);
      check_word("reg3_readback", d, 32'h2000);
      cpu_read(4'd1, d, st);
      check_word("reg1_zero", d, 32'd0);

      set_vec(32'h7FFF_0000, 32'h0002_0000);
      run("sat_pos", 1, 32'h1100, 32'h2100, 32'h3100, 0, 1, 1, 1, st);
      check_word("sat_pos_value", rd_word(32'h3100), 32'h7FFF_FFFF);
      set_vec(32'h8000_0000, 32'hFFFF_0000);
      run("sat_neg", 1, 32'h1200, 32'h2200, 32'h3200, 0, 1, 0, 2, st);
      check_word("sat_neg_value", rd_word(32'h3200), 32'h8000_0000);

      set_vec(32'hFFFE_0000, 32'h0001_0000);
      run("relu_on", 1, 32'h1300, 32'h2300, 32'h3300, 1, 1, 0, 0, st);
      check_word("relu_on_value", rd_word(32'h3300), 32'h0000_0000);
      run("relu_off", 1, 32'h1300, 32'h2300, 32'h3400, 0, 1, 0, 0, st);
      check_word("relu_off_value", rd_word(32'h3400), 32'hFFFF_0000);

      in_v.delete();
      bias_v.delete();
      for (int i = 0; i < 3; i++) begin
         in_v.push_back($urandom);
         bias_v.push_back($urandom);
      end
      run("wait_lat", 3, 32'h100, 32'h200, 32'h300, 0, 1, 2, 3, st);
      checks++;
      if (st == 0) begin
         errors++;
         $display("FAIL wait_lat_stall got=%0d exp=>0", st);
      end
      run("persist", 3, 32'h100, 32'h200, 32'h300, 0, 0, 1, 0, st);

      set_vec(32'h0, 32'h0);
      run("n_zero", 0, 32'h1000, 32'h2000, 32'h3000, 0, 1, 0, 0, st);
      check_word("n_zero_stall", st, 32'd0);

      for (int k = 0; k < 6; k++) begin
         in_v.delete();
         bias_v.delete();
         n = $urandom_range(1, 6);
         relu = $urandom_range(0, 1);
         for (int i = 0; i < n; i++) begin
            in_v.push_back($urandom_range(0, 1) ? $urandom : $urandom_range(0, 32'h0003_FFFF) - 32'h0002_0000);
            bias_v.push_back($urandom);
         end
         run("random", n, 32'h4000 + k*32'h100, 32'h5000 + k*32'h100, 32'h6000 + k*32'h100,
             relu, 1, $urandom_range(0, 3), $urandom_range(0, 4), st);
      end

      in_v.delete();
      bias_v.delete();
      for (int i = 0; i < 4; i++) begin
         in_v.push_back($urandom);
         bias_v.push_back($urandom);
      end
      wlat = 3;
      rlat = 1;
      push_expected(4, 32'h7000, 32'h7100, 32'h7200, 1);
      configure(4, 32'h7000, 32'h7100, 32'h7200, 1);
      cpu_write(4'd0, 32'd0);
      n = 0;
      while (n < LIMIT && !(mem.master_write && mem.master_address == 32'h7204)) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_word("rst_reached_wr_out", {31'd0, mem.master_write}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_word("rst_write_drop", {30'd0, mem.master_write, mem.master_read}, 32'd0);
      check_word("rst_addr_zero", mem.master_address, 32'd0);
      check_word("rst_wdata_zero", mem.master_writedata, 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b1;
      for (int r = 0; r < 7; r++) begin
         if (r != 1) begin
            cpu_read(r[3:0], d, st);
            check_word($sformatf("rst_reg%0d", r), d, 32'd0);
         end
      end
      in_v.delete();
      bias_v.delete();
      for (int i = 0; i < 3; i++) begin
         in_v.push_back($urandom);
         bias_v.push_back($urandom);
      end
      run("after_rst", 3, 32'h8000, 32'h8100, 32'h8200, 0, 1, 1, 2, st);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bias_relu.md
BIAS_RELU -- requirements
Module: bias_relu

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 slave_waitrequest  out  1  CPU-facing stall
 slave_address  in  4  word register index
 slave_read  in  1  CPU read strobe
 slave_readdata  out  32  CPU read data
 slave_write  in  1  CPU write strobe
 slave_writedata  in  32  CPU write data
 master_waitrequest  in  1  memory stall
 master_address  out  32  byte address
 master_read  out  1  memory read strobe
 master_readdata  in  32  memory read data
 master_readdatavalid  in  1  read data valid
 master_write  out  1  memory write strobe
 master_writedata  out  32  memory write data
REQ-002 The block SHALL decode these slave registers (index, default, meaning): 0, -, start on write / element count on read; 2, 0, input vector byte address (dot-product results); 3, 0, bias vector byte address; 4, 0, output vector byte address; 5, 0, length N in words; 6, 0, bit0 = ReLU enable.

Function
REQ-003 The block SHALL process element i = 0..N-1 as: read in[i] at reg2+4i, read bias[i] at reg3+4i, compute r = sat(in+bias), apply ReLU if enabled, write r to reg4+4i.
REQ-004 The block SHALL use states IDLE, RD_IN, WAIT_IN, RD_BIAS, WAIT_BIAS, WR_OUT.
REQ-005 In IDLE the block SHALL hold slave_waitrequest=0, all master strobes 0, and accept register writes in the same cycle.
REQ-006 A slave write to index 0 in IDLE SHALL clear the element counter and go to RD_IN, or stay in IDLE if N=0 (no master access).
REQ-007 In RD_IN/RD_BIAS the block SHALL assert master_read with a stable address until a cycle with master_waitrequest=0, then go to WAIT_IN/WAIT_BIAS.
REQ-008 In WAIT_IN/WAIT_BIAS the block SHALL capture master_readdata on the cycle master_readdatavalid=1, then go to RD_BIAS/WR_OUT respectively; no strobes asserted while waiting.
REQ-009 In WR_OUT the block SHALL assert master_write with stable address and data until master_waitrequest=0, then increment the counter and go to RD_IN if counter+1<N, else IDLE.
REQ-010 Arithmetic SHALL be signed 32-bit Q16.16 with a 33-bit intermediate sum; overflow SHALL saturate to 0x7FFFFFFF, underflow to 0x80000000.
REQ-011 ReLU SHALL replace any negative saturated result with 0x00000000; with ReLU disabled the saturated result passes unchanged.
REQ-012 Outside IDLE slave_waitrequest SHALL be 1; CPU accesses stall until return to IDLE; register writes are ignored while busy.
REQ-013 slave_readdata SHALL return the completed element count for index 0, the register value for indices 2-6, 0 otherwise; it SHALL be 0 when not IDLE.
REQ-014 master_writedata SHALL be 0 except in WR_OUT; master_address SHALL be 0 in IDLE/WAIT states.
REQ-015 Register configuration SHALL persist across runs; a new start reuses prior values.

Reset
REQ-016 Asserting rst_n low at any time, including mid-transfer, SHALL force IDLE, clear all registers and counter to 0, and drive all outputs low within the same cycle; any outstanding readdatavalid after reset SHALL be ignored.

Structure
REQ-017 The state enum, register index constants and Q16.16 saturation limits SHALL live in a shared package nn_accel_pkg.
REQ-018 Saturating add plus ReLU SHALL be a combinational sub-module sat_add_relu (inputs a, b, relu_en; output y).

Verification
REQ-019 N=1, in=0x00010000, bias=0x00008000, ReLU off -> writes 0x00018000 to reg4; reg0 reads 1.
REQ-020 N=1, in=0x7FFF0000, bias=0x00020000 -> writes 0x7FFFFFFF; in=0x80000000, bias=0xFFFF0000 -> writes 0x80000000.
REQ-021 N=1, in=0xFFFE0000, bias=0x00010000: ReLU on -> 0x00000000; ReLU off -> 0xFFFF0000.
REQ-022 N=3, reg2=0x100, reg3=0x200, reg4=0x300, memory waitrequest 2 cycles and readdatavalid 3 cycles late -> writes exactly at 0x300,0x304,0x308, read order in/bias per element, CPU read stalled until done.
REQ-023 N=0 start -> no master strobes, slave_waitrequest stays 0, reg0 reads 0.
REQ-024 rst_n low during WR_OUT of element 1 of N=4 -> master_write drops immediately, regs read 0, subsequent start with new config runs correctly.
